// File: rtl/his_readout_pkg.sv
// rtl/his_readout_pkg.sv - shared defaults and FSM encoding for the histogram readout
package his_readout_pkg;

    localparam int NB_DEFAULT    = 6;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/his_readout_if.sv
// rtl/his_readout_if.sv - histogram RAM port and (bin, count) result stream
interface his_readout_if
    import his_readout_pkg::*;
#(
    parameter int NB    = NB_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             ram_rd_en;
    logic [NB:0]      ram_rd_addr;
    logic [CNT_W-1:0] ram_rd_data;
    logic             ram_wr_en;
    logic [NB:0]      ram_wr_addr;

    logic             out_valid;
    logic             out_ready;
    logic [NB-1:0]    out_bin;
    logic [CNT_W-1:0] out_count;
    logic             out_last;

    modport master (
        output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr,
        output out_valid, out_bin, out_count, out_last,
        input  ram_rd_data, out_ready
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr,
        input  out_valid, out_bin, out_count, out_last,
        output ram_rd_data, out_ready
    );

endinterface

// File: rtl/his_readout_skid_fifo.sv
// rtl/his_readout_skid_fifo.sv - 2-entry skid FIFO holding returned {bin, count} pairs
module his_skid_fifo #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/his_readout.sv
// rtl/his_readout.sv - sweeps one histogram out of SRAM, streams bins, tracks the peak
module his_readout
    import his_readout_pkg::*;
#(
    parameter int NB            = NB_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             his_sel,
    output logic             busy,
    his_readout_if.master    bus,
    output logic [NB-1:0]    peak_addr,
    output logic [CNT_W-1:0] peak_count,
    output logic             peak_done
);
    localparam logic [NB:0] LAST_BIN = (NB+1)'((1 << NB) - 1);

    state_t               state, state_nx;
    logic                 his_sel_q;
    logic [NB:0]          issue_cnt;
    logic                 inflight;
    logic [NB-1:0]        inflight_bin;
    logic [1:0]           fifo_count;
    logic [NB+CNT_W-1:0]  fifo_head;
    logic [2:0]           occ;
    logic                 rd_en;
    logic                 start_ok;
    logic                 pop;

    his_skid_fifo #(.W(NB + CNT_W)) u_fifo (
        .clk       (clk),
        .res       (res),
        .push      (inflight),
        .push_data ({inflight_bin, bus.ram_rd_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.out_valid = (fifo_count != 2'd0);
    assign {bus.out_bin, bus.out_count} = fifo_head;
    assign bus.out_last  = bus.out_valid & (&bus.out_bin);
    assign pop           = bus.out_valid & bus.out_ready;

    // A beat leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
    assign occ = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        start_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_nx = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                rd_en = (occ < 3'd2);
                if (rd_en && (issue_cnt == LAST_BIN)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && bus.out_last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= ST_IDLE;
            his_sel_q    <= 1'b0;
            issue_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_bin <= '0;
            peak_addr    <= '0;
            peak_count   <= '0;
        end else begin
            state    <= state_nx;
            inflight <= rd_en;
            if (start_ok) begin
                his_sel_q  <= his_sel;
                issue_cnt  <= '0;
                peak_addr  <= '0;
                peak_count <= '0;
            end else begin
                if (rd_en) begin
                    inflight_bin <= issue_cnt[NB-1:0];
                    issue_cnt    <= issue_cnt + (NB+1)'(1);
                end
                // Strict compare: on ties the earliest (lowest) bin wins.
                if (inflight && (bus.ram_rd_data > peak_count)) begin
                    peak_count <= bus.ram_rd_data;
                    peak_addr  <= inflight_bin;
                end
            end
        end
    end

    assign busy            = (state != ST_IDLE);
    assign peak_done       = (state == ST_DONE);
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_en ? {his_sel_q, issue_cnt[NB-1:0]} : '0;
    assign bus.ram_wr_en   = CLEAR_ON_READ && inflight;
    assign bus.ram_wr_addr = bus.ram_wr_en ? {his_sel_q, inflight_bin} : '0;

endmodule
